atm_arbiter: RTL and testbench

ATM_ARBITER -- requirements
Module: atm_arbiter

---
 rtl/atm_arbiter.sv | 145 ++++++++++++++
 tb/tb_atm_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_arbiter.sv
// Round-robin arbiter that lets N_TERM terminals share one ATM core: it latches the
// winner's transaction, runs the core for TXN_CYCLES cycles and returns the response.
module atm_arbiter #(
  parameter int N_TERM     = 4,
  parameter int TXN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_TERM-1:0]      req,
  input  logic [3*N_TERM-1:0]    t_operation,
  input  logic [4*N_TERM-1:0]    t_acc_num,
  input  logic [16*N_TERM-1:0]   t_pin,
  input  logic [16*N_TERM-1:0]   t_new_pin,
  input  logic [32*N_TERM-1:0]   t_amount,
  input  logic [N_TERM-1:0]      t_language,
  output logic [N_TERM-1:0]      gnt,
  output logic [N_TERM-1:0]      done,
  output logic [31:0]            rsp_balance,
  output logic                   rsp_success,
  output logic                   busy,
  output logic                   atm_rst,
  output logic [2:0]             atm_operation,
  output logic [3:0]             atm_acc_num,
  output logic [15:0]            atm_pin,
  output logic [15:0]            atm_new_pin,
  output logic [31:0]            atm_amount,
  output logic                   atm_language,
  input  logic [31:0]            atm_balance,
  input  logic                   atm_success,
  input  logic [2:0]             atm_state
);

  localparam int TW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int CW = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   last_grant;
  logic [TW-1:0]   winner;
  logic [CW-1:0]   cnt;
  logic [2:0]      win_op;
  logic            op_ok;
  logic            last_run;
  logic            drive;

  logic [2:0]      lat_op;
  logic [3:0]      lat_acc;
  logic [15:0]     lat_pin;
  logic [15:0]     lat_new_pin;
  logic [31:0]     lat_amount;
  logic            lat_lang;

  // The core's state is only observed by the bench.
  logic            core_state_unused;
  assign core_state_unused = ^atm_state;

  // Search from last_grant+1; iterating downwards lets the nearest requester win.
  always_comb begin
    winner = '0;
    for (int i = N_TERM; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % N_TERM]) winner = TW'((int'(last_grant) + i) % N_TERM);
    end
  end

  assign win_op   = t_operation[3*winner +: 3];
  assign op_ok    = (win_op >= 3'd3) && (win_op <= 3'd6);
  assign last_run = (cnt == CW'(TXN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = op_ok ? CLR : RESP;
      CLR:     state_nxt = RUN;
      RUN:     if (last_run) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state-holding registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      last_grant  <= TW'(N_TERM - 1);
      cnt         <= '0;
      lat_op      <= '0;
      lat_acc     <= '0;
      lat_pin     <= '0;
      lat_new_pin <= '0;
      lat_amount  <= '0;
      lat_lang    <= 1'b0;
      rsp_balance <= '0;
      rsp_success <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt         <= N_TERM'(1) << winner;
          last_grant  <= winner;
          cnt         <= '0;
          lat_op      <= win_op;
          lat_acc     <= t_acc_num[4*winner +: 4];
          lat_pin     <= t_pin[16*winner +: 16];
          lat_new_pin <= t_new_pin[16*winner +: 16];
          lat_amount  <= t_amount[32*winner +: 32];
          lat_lang    <= t_language[winner];
          if (!op_ok) begin
            rsp_balance <= '0;
            rsp_success <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_run) begin
            rsp_balance <= atm_balance;
            rsp_success <= atm_success;
          end
        end
        RESP:    gnt <= '0;
        default: ;
      endcase
    end
  end

  // The core sees the latched payload only while it is being cleared or run.
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == RESP) ? gnt : '0;
    atm_rst       = (state == RUN);
    drive         = (state == CLR) || (state == RUN);
    atm_operation = drive ? lat_op      : '0;
    atm_acc_num   = drive ? lat_acc     : '0;
    atm_pin       = drive ? lat_pin     : '0;
    atm_new_pin   = drive ? lat_new_pin : '0;
    atm_amount    = drive ? lat_amount  : '0;
    atm_language  = drive ? lat_lang    : 1'b0;
  end

endmodule

// File: tb/tb_atm_arbiter.sv
// Bench for atm_arbiter: a transaction-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_atm_arbiter;

  localparam int TXN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [11:0]   t_operation = '0;
  logic [15:0]   t_acc_num = '0;
  logic [63:0]   t_pin = '0;
  logic [63:0]   t_new_pin = '0;
  logic [127:0]  t_amount = '0;
  logic [3:0]    t_language = '0;
  logic [3:0]    gnt, done;
  logic [31:0]   rsp_balance;
  logic          rsp_success, busy, atm_rst;
  logic [2:0]    atm_operation;
  logic [3:0]    atm_acc_num;
  logic [15:0]   atm_pin, atm_new_pin;
  logic [31:0]   atm_amount;
  logic          atm_language;
  logic [31:0]   atm_balance;
  logic          atm_success;
  logic [2:0]    atm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  atm_arbiter #(.N_TERM(4), .TXN_CYCLES(TXN)) dut (
    .clk(clk), .rst(rst), .req(req),
    .t_operation(t_operation), .t_acc_num(t_acc_num), .t_pin(t_pin),
    .t_new_pin(t_new_pin), .t_amount(t_amount), .t_language(t_language),
    .gnt(gnt), .done(done), .rsp_balance(rsp_balance), .rsp_success(rsp_success),
    .busy(busy), .atm_rst(atm_rst), .atm_operation(atm_operation),
    .atm_acc_num(atm_acc_num), .atm_pin(atm_pin), .atm_new_pin(atm_new_pin),
    .atm_amount(atm_amount), .atm_language(atm_language),
    .atm_balance(atm_balance), .atm_success(atm_success), .atm_state(atm_state)
  );

  always #5 clk = ~clk;

  // Toy ATM core: a known PIN reports acc*1000, anything else scrambles the payload.
  function automatic logic [32:0] core_f(input logic [2:0] op, input logic [3:0] acc,
                                         input logic [15:0] pin, input logic [15:0] npin,
                                         input logic [31:0] amt, input logic lang);
    logic [31:0] b;
    logic        s;
    if (pin == 16'd1234) begin
      b = 32'(acc) * 32'd1000;
      s = ~lang;
    end else begin
      b = amt ^ {npin, pin} ^ {29'd0, op};
      s = lang;
    end
    return {s, b};
  endfunction

  assign {atm_success, atm_balance} = atm_rst ? core_f(atm_operation, atm_acc_num, atm_pin,
                                        atm_new_pin, atm_amount, atm_language) : 33'd0;
  assign atm_state = atm_rst ? 3'd1 : 3'd7;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: one transaction at a time, described by its position t on a timeline.
  bit          m_active = 0;
  bit          m_ok = 0;
  int          m_t = 0;
  int          m_done_t = 0;
  int          m_win = 0;
  int          m_last = 3;
  logic [71:0] m_data = '0;
  logic [31:0] m_bal = '0;
  logic        m_succ = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_active = 0;
      m_last   = 3;
      m_bal    = '0;
      m_succ   = 1'b0;
      m_data   = '0;
    end else if (m_active) begin
      if (m_t == m_done_t) m_active = 0;
      else begin
        m_t++;
        if (m_t == m_done_t)
          {m_succ, m_bal} = core_f(m_data[71:69], m_data[68:65], m_data[64:49],
                                   m_data[48:33], m_data[32:1], m_data[0]);
      end
    end else if (req != 0) begin
      for (int i = 4; i >= 1; i--) if (req[(m_last + i) % 4]) m_win = (m_last + i) % 4;
      m_last   = m_win;
      m_data   = {t_operation[3*m_win +: 3], t_acc_num[4*m_win +: 4], t_pin[16*m_win +: 16],
                  t_new_pin[16*m_win +: 16], t_amount[32*m_win +: 32], t_language[m_win]};
      m_ok     = (m_data[71:69] >= 3) && (m_data[71:69] <= 6);
      m_done_t = m_ok ? TXN + 2 : 1;
      m_t      = 1;
      m_active = 1;
      if (!m_ok) begin
        m_bal  = '0;
        m_succ = 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    logic [3:0] e_gnt;
    logic       e_rst, e_drive;
    @(negedge clk);
    e_gnt   = m_active ? 4'(1 << m_win) : 4'd0;
    e_rst   = m_active && m_ok && m_t >= 2 && m_t <= TXN + 1;
    e_drive = m_active && m_ok && m_t <= TXN + 1;
    check("gnt", 128'(gnt), 128'(e_gnt));
    check("done", 128'(done), 128'((m_active && m_t == m_done_t) ? e_gnt : 4'd0));
    check("busy", 128'(busy), 128'(m_active));
    check("atm_rst", 128'(atm_rst), 128'(e_rst));
    check("atm_data", 128'({atm_operation, atm_acc_num, atm_pin, atm_new_pin, atm_amount,
                            atm_language}), 128'(e_drive ? m_data : 72'd0));
    check("rsp", 128'({rsp_success, rsp_balance}), 128'({m_succ, m_bal}));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_term(input int i, input logic [2:0] op, input logic [3:0] acc,
                          input logic [15:0] pin, input logic [15:0] npin,
                          input logic [31:0] amt, input logic lang);
    t_operation[3*i +: 3] = op;
    t_acc_num[4*i +: 4]   = acc;
    t_pin[16*i +: 16]     = pin;
    t_new_pin[16*i +: 16] = npin;
    t_amount[32*i +: 32]  = amt;
    t_language[i]         = lang;
  endtask

  task automatic wait_done(input int c0, input int limit, output int idx, output int lat);
    idx = -1;
    lat = -1;
    for (int j = 0; j < limit; j++) begin
      next_neg();
      if (done != 0) begin
        idx = oh_idx(done);
        lat = cyc - c0;
        return;
      end
    end
  endtask

  initial begin
    int c0, idx, lat, n, dn;
    int ord[5];
    int tim[5];
    #1 rst = 1'b0;

    // Reset state, then idle after release.
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_outs", 128'({gnt, done, rsp_balance, rsp_success, atm_rst, atm_amount}), 128'(0));
    tick();
    rst = 1'b1;
    repeat (3) next_neg();
    check("idle_outs", 128'({gnt, done, busy, atm_rst}), 128'(0));

    // Single request on terminal 0; req dropped right after the grant.
    tick();
    set_term(0, 3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0);
    req = 4'b0001;
    c0  = cyc;
    for (int j = 1; j <= 7; j++) begin
      next_neg();
      if (j == 1) req = 4'b0000;
      check("single_gnt", 128'(gnt), 128'((j <= 6) ? 4'b0001 : 4'b0000));
      check("single_atm_rst", 128'(atm_rst), 128'((j >= 2 && j <= 5) ? 1 : 0));
      check("single_done", 128'(done), 128'((j == 6) ? 4'b0001 : 4'b0000));
      if (j == 6) check("single_rsp", 128'({rsp_success, rsp_balance}), 128'({1'b1, 32'd1000}));
    end

    // Payload stability: the winner's amount changes after the grant.
    tick();
    set_term(1, 3'd4, 4'd2, 16'd1234, 16'd55, 32'd1000, 1'b0);
    req = 4'b0010;
    for (int j = 1; j <= 6; j++) begin
      next_neg();
      if (j == 1) begin
        t_amount[32 +: 32] = 32'd5;
        req = 4'b0000;
      end
      if (j >= 2 && j <= 5) check("hold_amount", 128'(atm_amount), 128'(32'd1000));
      if (j == 6) begin
        check("hold_done", 128'(done), 128'(4'b0010));
        check("hold_rsp", 128'({rsp_success, rsp_balance}), 128'({1'b1, 32'd2000}));
      end
    end

    // Reject: operation 7 completes one cycle after the sampling edge.
    tick();
    set_term(2, 3'd7, 4'd9, 16'd1, 16'd2, 32'd77, 1'b1);
    req = 4'b0100;
    next_neg();
    req = 4'b0000;
    check("rej_done", 128'(done), 128'(4'b0100));
    check("rej_rsp", 128'({rsp_success, rsp_balance}), 128'(0));
    check("rej_atm_rst", 128'(atm_rst), 128'(0));
    repeat (2) next_neg();

    // Contention after reset: all four held, served 0,1,2,3,0 every 7 cycles.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_term(i, 3'(3 + i), 4'(i), 16'd1234, 16'd0, 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      ord[i] = -1;
      tim[i] = -1;
    end
    req = 4'b1111;
    c0  = cyc;
    n   = 0;
    for (int j = 0; j < 60 && n < 5; j++) begin
      next_neg();
      if (done != 0) begin
        ord[n] = oh_idx(done);
        tim[n] = cyc;
        n++;
      end
    end
    req = 4'b0000;
    check("cont_count", 128'(n), 128'(5));
    check("cont_first_lat", 128'(tim[0] - c0), 128'(6));
    for (int i = 0; i < 5; i++) check("cont_order", 128'(ord[i]), 128'(i % 4));
    for (int i = 1; i < 5; i++) check("cont_gap", 128'(tim[i] - tim[i-1]), 128'(7));
    repeat (3) next_neg();

    // Reset in cycle k+3 abandons the transaction; the next one runs normally.
    tick();
    set_term(3, 3'd5, 4'd3, 16'd1234, 16'd0, 32'd9, 1'b0);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", 128'({gnt, done, busy, atm_rst, atm_amount}), 128'(0));
    tick();
    rst = 1'b1;
    dn = 0;
    for (int j = 0; j < 8; j++) begin
      next_neg();
      if (done != 0) dn++;
    end
    check("mid_rst_no_done", 128'(dn), 128'(0));
    tick();
    req = 4'b1000;
    c0  = cyc;
    wait_done(c0, 20, idx, lat);
    req = 4'b0000;
    check("after_rst_idx", 128'(idx), 128'(3));
    check("after_rst_lat", 128'(lat), 128'(6));
    check("after_rst_rsp", 128'({rsp_success, rsp_balance}), 128'({1'b1, 32'd3000}));

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 600; k++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst = 1'b0;
      req = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++)
        set_term(i, 3'($urandom_range(0, 7)), 4'($urandom),
                 ($urandom_range(0, 1) == 1) ? 16'd1234 : 16'($urandom),
                 16'($urandom), $urandom, 1'($urandom));
    end
    tick();
    rst = 1'b1;
    req = 4'b0000;
    repeat (10) next_neg();
    check("drain_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
